// File: rtl/mux_seq_pkg.sv
// Shared definitions for the mux select sequencer.
//   WORD_W   : width of the serialised word
//   SEL_W    : width of the mux select
//   SEL_LAST : highest select index
//   state_e  : sequencer FSM states
//   edge_idx : first/last index of a sweep for a given direction
package mux_seq_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned SEL_W    = 5;
  localparam int unsigned SEL_LAST = 31;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // msb = 0 -> index 0, msb = 1 -> index SEL_LAST. The start index of a sweep is
  // edge_idx(dir) and the end index is edge_idx(!dir).
  function automatic logic [SEL_W-1:0] edge_idx(input logic msb);
    return msb ? SEL_W'(SEL_LAST) : '0;
  endfunction

endpackage

// File: rtl/step_divider.sv
// Dwell counter for the select sweep.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear to 0 (wins over en)
//   en         : count enable
//   cnt        : current position inside the dwell window
//   tick       : high in the last cycle of a window (cnt == DIV-1 while enabled)
module step_divider #(
  parameter int unsigned DIV = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    clr,
  input  logic                                    en,
  output logic [((DIV > 1) ? $clog2(DIV) : 1)-1:0] cnt,
  output logic                                    tick
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CntMax);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Sequencer feeding a 32-to-1 bit-select mux. Accepts a word over valid/ready,
// holds it on w_o and sweeps sel_o across all 32 indices (LSB- or MSB-first),
// dwelling DIV clocks per index. Supports back-to-back frames and abort.
//   clk, rst_n : clock, async active-low reset
//   load_valid : word offered
//   load_ready : sequencer can take a word this cycle
//   load_data  : word to serialise, bit i selected when sel_o == i
//   msb_first  : sweep direction, sampled at handshake
//   abort      : synchronous frame cancel, highest priority
//   w_o        : registered word for the mux data inputs
//   sel_o      : registered mux select
//   frame_o    : high while a sweep runs
//   step_o     : high in the first cycle of each index window
//   done_o     : high in the last cycle of a completed frame
module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [0:WORD_W-1]   load_data,
  input  logic                msb_first,
  input  logic                abort,
  output logic [0:WORD_W-1]   w_o,
  output logic [SEL_W-1:0]    sel_o,
  output logic                frame_o,
  output logic                step_o,
  output logic                done_o
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

  state_e            state_q, state_d;
  logic [0:WORD_W-1] w_q, w_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              dir_q, dir_d;

  logic [CntW-1:0]   div_cnt;
  logic              div_tick;
  logic              div_clr;
  logic              div_en;

  logic              running;
  logic              last_cycle;
  logic              handshake;

  step_divider #(
    .DIV (DIV)
  ) u_step_divider (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (div_clr),
    .en    (div_en),
    .cnt   (div_cnt),
    .tick  (div_tick)
  );

  assign running    = (state_q == RUN);
  assign last_cycle = running && div_tick && (sel_q == edge_idx(!dir_q));

  // Ready reads 1 throughout reset so an upstream source never sees a stall
  // that depends on the (reset) FSM state.
  assign load_ready = !rst_n || ((!running || last_cycle) && !abort);
  assign handshake  = load_valid && load_ready;

  assign div_en  = running;
  assign div_clr = abort || handshake;

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    if (abort) begin
      state_d = IDLE;
      sel_d   = '0;
    end else if (handshake) begin
      // Covers both a load from IDLE and a seamless reload in last_cycle.
      state_d = RUN;
      w_d     = load_data;
      dir_d   = msb_first;
      sel_d   = edge_idx(msb_first);
    end else if (last_cycle) begin
      state_d = IDLE;
    end else if (running && div_tick) begin
      sel_d = dir_q ? sel_q - SEL_W'(1) : sel_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q     <= '0;
      sel_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
    end
  end

  assign w_o     = w_q;
  assign sel_o   = sel_q;
  assign frame_o = running;
  assign step_o  = running && (div_cnt == '0);
  assign done_o  = last_cycle && !abort;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Randomised bench for mux_sel_sequencer with DIV = 4 and DIV = 1 instances,
// checked every cycle against a frame-level model (frame position t, word, direction).
module tb_mux_sel_sequencer;

  localparam int NI = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lv [NI];
  logic [0:31] ld [NI];
  logic        mf [NI];
  logic        ab [NI];
  logic        lr [NI];
  logic [0:31] wo [NI];
  logic [4:0]  so [NI];
  logic        fo [NI];
  logic        sto[NI];
  logic        dno[NI];

  always #5 clk = ~clk;

  mux_sel_sequencer #(.DIV(4)) u_div4 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv[0]), .load_ready(lr[0]), .load_data(ld[0]),
    .msb_first(mf[0]), .abort(ab[0]), .w_o(wo[0]), .sel_o(so[0]), .frame_o(fo[0]),
    .step_o(sto[0]), .done_o(dno[0])
  );

  mux_sel_sequencer #(.DIV(1)) u_div1 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv[1]), .load_ready(lr[1]), .load_data(ld[1]),
    .msb_first(mf[1]), .abort(ab[1]), .w_o(wo[1]), .sel_o(so[1]), .frame_o(fo[1]),
    .step_o(sto[1]), .done_o(dno[1])
  );

  int n_cmp = 0;
  int n_err = 0;

  // Frame-level model: m_t counts cycles since the start of the current frame.
  bit          m_run [NI];
  int          m_t   [NI];
  logic [0:31] m_w   [NI];
  bit          m_dir [NI];
  int          m_hold[NI];
  logic [0:31] obs   [NI];

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int exp_sel(input int i);
    int k;
    if (!m_run[i]) return m_hold[i];
    k = m_t[i] / div_of(i);
    return m_dir[i] ? 31 - k : k;
  endfunction

  function automatic bit exp_last(input int i);
    return m_run[i] && (m_t[i] == 32 * div_of(i) - 1);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_run[i] = 0; m_t[i] = 0; m_w[i] = '0; m_dir[i] = 0; m_hold[i] = 0; obs[i] = '0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      string p;
      bit    rdy;
      bit    dn;
      logic [0:31] es;
      p   = $sformatf("div%0d_", div_of(i));
      rdy = !rst_n || ((!m_run[i] || exp_last(i)) && !ab[i]);
      dn  = rst_n && exp_last(i) && !ab[i];
      check_eq({p, "ready"}, 32'(lr[i]), 32'(rdy));
      check_eq({p, "frame"}, 32'(fo[i]), 32'(m_run[i]));
      check_eq({p, "sel"},   32'(so[i]), 32'(exp_sel(i)));
      check_eq({p, "step"},  32'(sto[i]), 32'(m_run[i] && (m_t[i] % div_of(i) == 0)));
      check_eq({p, "done"},  32'(dno[i]), 32'(dn));
      check_eq({p, "w"},     wo[i], m_w[i]);
      if (m_run[i]) obs[i][m_t[i] / div_of(i)] = wo[i][so[i]];
      if (dn) begin
        for (int k = 0; k < 32; k++) es[k] = m_w[i][m_dir[i] ? 31 - k : k];
        check_eq({p, "mux_stream"}, obs[i], es);
      end
    end
  endtask

  task automatic model_step();
    if (!rst_n) return;
    for (int i = 0; i < NI; i++) begin
      bit last;
      bit hs;
      last = exp_last(i);
      hs   = lv[i] && (!m_run[i] || last) && !ab[i];
      if (ab[i]) begin
        m_run[i] = 0; m_hold[i] = 0;
      end else if (hs) begin
        m_w[i] = ld[i]; m_dir[i] = mf[i]; m_run[i] = 1; m_t[i] = 0; obs[i] = '0;
      end else if (m_run[i]) begin
        if (last) begin
          m_hold[i] = m_dir[i] ? 0 : 31;
          m_run[i]  = 0;
        end else begin
          m_t[i]++;
        end
      end
    end
  endtask

  // Inputs change on the falling edge; outputs are checked 1 time unit later.
  task automatic run_cycle();
    #1;
    check_all();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [0:31] d, input logic m, input logic a);
    for (int i = 0; i < NI; i++) begin
      lv[i] = v; ld[i] = d; mf[i] = m; ab[i] = a;
    end
  endtask

  task automatic idle_cycles(input int n);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    for (int c = 0; c < n; c++) run_cycle();
  endtask

  initial begin
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    run_cycle();
    rst_n = 1'b1;
    idle_cycles(2);

    // LSB-first frame
    drive(1'b1, 32'hA5A5_0F0F, 1'b0, 1'b0);
    run_cycle();
    idle_cycles(132);

    // MSB-first frame, then idle holding the final index
    drive(1'b1, 32'h1234_5678, 1'b1, 1'b0);
    run_cycle();
    idle_cycles(132);

    // Back-to-back: valid held, second word taken in the done cycle
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    run_cycle();
    drive(1'b1, 32'h0F1E_2D3C, 1'b1, 1'b0);
    for (int c = 0; c < 128; c++) run_cycle();
    idle_cycles(132);

    // Abort once sel_o reaches 10 on the DIV=4 instance
    drive(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0);
    run_cycle();
    idle_cycles(41);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    run_cycle();
    idle_cycles(3);
    // Abort with valid in IDLE: no handshake
    drive(1'b1, 32'h5555_AAAA, 1'b1, 1'b1);
    run_cycle();
    idle_cycles(3);

    // Reset asserted mid-frame
    drive(1'b1, 32'h8001_7FFE, 1'b0, 1'b0);
    run_cycle();
    idle_cycles(20);
    rst_n = 1'b0;
    model_reset();
    drive(1'b1, 32'h1111_2222, 1'b1, 1'b0);
    run_cycle();
    rst_n = 1'b1;
    idle_cycles(2);

    // Random traffic, independent per instance
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NI; i++) begin
        lv[i] = ($urandom_range(0, 2) == 0);
        ld[i] = $urandom;
        mf[i] = $urandom_range(0, 1) == 1;
        ab[i] = ($urandom_range(0, 199) < 2);
      end
      run_cycle();
    end
    idle_cycles(140);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
